ysyx_22050598_ifu_mem_resp: RTL and testbench
=============================================

YSYX_22050598_IFU_MEM_RESP -- requirements
Module: ysyx_22050598_ifu_mem_resp

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter TIMEOUT SHALL default to 255 and give the maximum cycles to wait for ram_rvalid per beat.
REQ-003 Ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_mem_valid  in  1  line-read request; held high by the cache until ready
- ifu_mem_addr  in  64  request address; bits [3:0] ignored
- ifu_mem_data  out  128  assembled line; valid when ifu_mem_ready=1
- ifu_mem_ready  out  1  one-cycle completion pulse
- ram_req  out  1  backing-memory 64-bit read request; level
- ram_addr  out  64  backing-memory address, 8-byte aligned
- ram_rvalid  in  1  backing read data valid; only meaningful while ram_req=1
- ram_rdata  in  64  backing read data
- err  out  1  sticky timeout flag
- resp_cnt  out  32  count of completed responses

Function
REQ-004 The FSM SHALL have states IDLE, BEAT0, BEAT1, RESP and DRAIN.
REQ-005 In IDLE with ifu_mem_valid=1, the block SHALL latch line = {ifu_mem_addr[63:4],4'b0} and go to BEAT0 next cycle.
REQ-006 In BEAT0, ram_req SHALL be 1 and ram_addr SHALL be line.
- On ram_rvalid: capture ram_rdata into data[63:0] and go to BEAT1.
REQ-007 In BEAT1, ram_req SHALL be 1 and ram_addr SHALL be line+8.
- On ram_rvalid: capture ram_rdata into data[127:64] and go to RESP.
REQ-008 In RESP, ifu_mem_ready SHALL be 1 for exactly one cycle, resp_cnt SHALL increment, and the next state SHALL be IDLE.
REQ-009 Minimum latency SHALL be 3 cycles: ifu_mem_ready is high in cycle N+3 when valid is sampled in IDLE at cycle N and ram_rvalid is high on the first cycle of each beat.
REQ-010 ifu_mem_data SHALL hold the last assembled line between responses.
- It SHALL never change while ifu_mem_ready=1.
REQ-011 ram_req SHALL be 0 in IDLE, RESP and DRAIN-complete cycles.
- ram_addr SHALL be stable while ram_req=1 and ram_rvalid=0.
REQ-012 A new request SHALL be sampled no earlier than the IDLE cycle after RESP.
- Valid still high during RESP SHALL NOT start a second transaction in that cycle.
REQ-013 Abort: if ifu_mem_valid=0 while in BEAT0 or BEAT1 (flush), the block SHALL go to DRAIN.
- DRAIN holds ram_req=1 at the current ram_addr until ram_rvalid, then goes to IDLE.
- No ifu_mem_ready is issued, data is not updated and resp_cnt is unchanged.
REQ-014 Abort with simultaneous ram_rvalid in BEAT0 or BEAT1 SHALL go directly to IDLE without response.
REQ-015 A per-beat wait counter SHALL clear on entry to each beat and on each ram_rvalid, and increment otherwise while ram_req=1.
REQ-016 When the wait counter reaches TIMEOUT without ram_rvalid:
- err SHALL be set (sticky).
- The beat's data half SHALL be written as 0.
- The FSM SHALL advance as if ram_rvalid had arrived. In BEAT1 this yields a RESP pulse, so the cache never hangs.
REQ-017 resp_cnt SHALL wrap from 32'hFFFFFFFF to 0.
REQ-018 ram_rvalid arriving while ram_req=0 SHALL be ignored.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL reset as follows regardless of state, including mid-beat:
- state = IDLE
- ifu_mem_ready = 0, ram_req = 0, ram_addr = 0
- ifu_mem_data = 0, err = 0, resp_cnt = 0, wait counter = 0
REQ-020 A ram_rvalid arriving in the cycle after reset SHALL be ignored per REQ-018.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic read: valid=1, addr=0x8000_0004; ram_rvalid immediate with data 0x1111 then 0x2222.
  -> ram_addr 0x8000_0000, then 0x8000_0008; ready at cycle 3; data=0x…2222_…1111; resp_cnt=1.
- Wait states: 2 stall cycles per beat.
  -> ready at cycle 7; ram_addr stable during stalls; one ready pulse.
- Flush: valid drops in BEAT0 with ram_rvalid delayed 3 cycles.
  -> DRAIN until rvalid, then IDLE; no ready; data and resp_cnt unchanged.
- Timeout: TIMEOUT=4, ram_rvalid never asserted.
  -> err=1 after 4 cycles in BEAT0 and again in BEAT1; ready pulse with data=0; err stays 1 until rst.
- Back-to-back: valid held high across two lines, 0x8000_0000 then 0x8000_0010.
  -> two ready pulses separated by at least one IDLE cycle; resp_cnt=2.
- Reset mid-BEAT1: rst=1 for 1 cycle.
  -> all outputs 0 next cycle; a stale ram_rvalid is ignored; the next request is served normally.

Source files
------------

// File: rtl/ysyx_22050598_ifu_mem_resp.sv
// ysyx_22050598_ifu_mem_resp
//
// Serves a 128-bit instruction-cache line fill by issuing two 64-bit reads
// to the backing memory (low half first) and returning the assembled line
// with a one-cycle ready pulse. A per-beat wait counter bounds how long a
// beat may stall. On expiry the beat completes with zero data and err is set,
// so the cache is never left waiting. If the cache drops its request
// mid-line, the outstanding beat is drained and no response is returned.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   ifu_mem_valid   line-read request, held by the cache until ready
//   ifu_mem_addr    request address; bits [3:0] are ignored
//   ifu_mem_data    last assembled line; stable while ifu_mem_ready is high
//   ifu_mem_ready   one-cycle completion pulse
//   ram_req         backing read request (level)
//   ram_addr        backing read address, 8-byte aligned
//   ram_rvalid      backing read data valid; only looked at while ram_req=1
//   ram_rdata       backing read data
//   err             sticky beat-timeout flag
//   resp_cnt        number of completed responses (wraps)
//
// state | meaning
// IDLE  | waiting for a request; ram_req low
// BEAT0 | reading line+0 into the low half
// BEAT1 | reading line+8 into the high half
// RESP  | ifu_mem_ready pulse; new requests ignored this cycle
// DRAIN | request withdrawn; waiting for the outstanding beat to finish

module ysyx_22050598_ifu_mem_resp #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ifu_mem_valid,
    input  logic [63:0]  ifu_mem_addr,
    output logic [127:0] ifu_mem_data,
    output logic         ifu_mem_ready,
    output logic         ram_req,
    output logic [63:0]  ram_addr,
    input  logic         ram_rvalid,
    input  logic [63:0]  ram_rdata,
    output logic         err,
    output logic [31:0]  resp_cnt
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // The beat gives up in its TIMEOUT-th cycle, i.e. when the counter
    // would reach TIMEOUT on this edge.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RESP, DRAIN} state_t;

    state_t        state;
    logic [63:0]   line;
    logic [63:0]   data_lo;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          beat_done;
    logic [63:0]   beat_data;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^ifu_mem_addr[3:0];

    always_comb begin
        timeout_hit = !ram_rvalid && (wait_cnt == WAIT_LAST);
        beat_done   = ram_rvalid || timeout_hit;
        beat_data   = ram_rvalid ? ram_rdata : 64'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            line          <= 64'd0;
            data_lo       <= 64'd0;
            wait_cnt      <= '0;
            ifu_mem_data  <= 128'd0;
            ifu_mem_ready <= 1'b0;
            ram_req       <= 1'b0;
            ram_addr      <= 64'd0;
            err           <= 1'b0;
            resp_cnt      <= 32'd0;
        end else begin
            ifu_mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifu_mem_valid) begin
                        line     <= {ifu_mem_addr[63:4], 4'h0};
                        ram_addr <= {ifu_mem_addr[63:4], 4'h0};
                        ram_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= BEAT0;
                    end
                end
                BEAT0, BEAT1, DRAIN: begin
                    if (timeout_hit) begin
                        err <= 1'b1;
                    end
                    if (beat_done) begin
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                    // A withdrawn request keeps ram_req up until the memory
                    // finishes the beat already in flight, then discards it.
                    if (state == DRAIN || !ifu_mem_valid) begin
                        if (beat_done) begin
                            ram_req <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            state   <= DRAIN;
                        end
                    end else if (beat_done) begin
                        if (state == BEAT0) begin
                            data_lo  <= beat_data;
                            ram_addr <= line + 64'd8;
                            state    <= BEAT1;
                        end else begin
                            // Output line only changes on the edge into RESP.
                            ifu_mem_data  <= {beat_data, data_lo};
                            ifu_mem_ready <= 1'b1;
                            ram_req       <= 1'b0;
                            state         <= RESP;
                        end
                    end
                end
                RESP: begin
                    resp_cnt <= resp_cnt + 32'd1;
                    state    <= IDLE;
                end
                default: begin
                    ram_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050598_ifu_mem_resp.sv
// Bench for ysyx_22050598_ifu_mem_resp (TIMEOUT overridden to 4).
// Each line read is described by its per-beat stall counts; the expected
// cycle-by-cycle ram_req / ram_addr / ready / data / err values are derived
// from beat lengths: a beat lasts stalls+1 cycles, or TIMEOUT cycles if the
// memory never answers.

module tb_ysyx_22050598_ifu_mem_resp;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         ifu_mem_valid;
    logic [63:0]  ifu_mem_addr;
    logic [127:0] ifu_mem_data;
    logic         ifu_mem_ready;
    logic         ram_req;
    logic [63:0]  ram_addr;
    logic         ram_rvalid;
    logic [63:0]  ram_rdata;
    logic         err;
    logic [31:0]  resp_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [127:0] exp_data;
    logic [31:0]  exp_cnt;
    logic         exp_err;

    ysyx_22050598_ifu_mem_resp #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_mem_valid (ifu_mem_valid),
        .ifu_mem_addr  (ifu_mem_addr),
        .ifu_mem_data  (ifu_mem_data),
        .ifu_mem_ready (ifu_mem_ready),
        .ram_req       (ram_req),
        .ram_addr      (ram_addr),
        .ram_rvalid    (ram_rvalid),
        .ram_rdata     (ram_rdata),
        .err           (err),
        .resp_cnt      (resp_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of an idle cycle.
    task automatic idle_checks();
        chk("idle_req", 128'(ram_req), 128'(1'b0));
        chk("idle_ready", 128'(ifu_mem_ready), 128'(1'b0));
        chk("idle_data", ifu_mem_data, exp_data);
        chk("idle_cnt", 128'(resp_cnt), 128'(exp_cnt));
        chk("idle_err", 128'(err), 128'(exp_err));
    endtask

    // Full line read. Entered and left at the negedge of an idle cycle.
    // s0/s1: stall cycles before rvalid in each beat (>= TMO: never answers).
    // keep: leave ifu_mem_valid high through the response (back-to-back).
    task automatic read_line(input logic [63:0] a, input int s0, input int s1,
                             input bit keep, input logic [63:0] d0, input logic [63:0] d1);
        logic [63:0] ln;
        int l0, l1, last;
        ln   = {a[63:4], 4'h0};
        l0   = (s0 < TMO) ? s0 + 1 : TMO;
        l1   = (s1 < TMO) ? s1 + 1 : TMO;
        last = l0 + l1 + 1;
        idle_checks();
        ifu_mem_valid = 1'b1;
        ifu_mem_addr  = a;
        ram_rvalid    = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == l0 + 1 && s0 >= TMO) exp_err = 1'b1;
            if (c == last && s1 >= TMO) exp_err = 1'b1;
            if (c == last) exp_data = {(s1 < TMO) ? d1 : 64'd0, (s0 < TMO) ? d0 : 64'd0};
            chk("rd_req", 128'(ram_req), 128'(c < last));
            if (c < last) chk("rd_addr", 128'(ram_addr), 128'((c <= l0) ? ln : ln + 64'd8));
            chk("rd_ready", 128'(ifu_mem_ready), 128'(c == last));
            chk("rd_data", ifu_mem_data, exp_data);
            chk("rd_err", 128'(err), 128'(exp_err));
            ram_rvalid = 1'b0;
            ram_rdata  = {$urandom, $urandom};
            if (s0 < TMO && c == s0 + 1) begin
                ram_rvalid = 1'b1;
                ram_rdata  = d0;
            end
            if (s1 < TMO && c == l0 + 1 + s1) begin
                ram_rvalid = 1'b1;
                ram_rdata  = d1;
            end
            if (c == last) begin
                ifu_mem_valid = keep;
                exp_cnt = exp_cnt + 32'd1;
            end
        end
        @(negedge clk);
        ram_rvalid = 1'b0;
    endtask

    // Request withdrawn during the first beat. valid drops in beat cycle
    // drop_c, the memory answers in beat cycle rv_c (drop_c <= rv_c <= TMO).
    task automatic read_flush(input logic [63:0] a, input int drop_c, input int rv_c);
        logic [63:0] ln;
        ln = {a[63:4], 4'h0};
        idle_checks();
        ifu_mem_valid = 1'b1;
        ifu_mem_addr  = a;
        ram_rvalid    = 1'b0;
        for (int c = 1; c <= rv_c + 1; c++) begin
            @(negedge clk);
            chk("fl_req", 128'(ram_req), 128'(c <= rv_c));
            if (c <= rv_c) chk("fl_addr", 128'(ram_addr), 128'(ln));
            chk("fl_ready", 128'(ifu_mem_ready), 128'(1'b0));
            chk("fl_data", ifu_mem_data, exp_data);
            chk("fl_err", 128'(err), 128'(exp_err));
            if (c == drop_c) ifu_mem_valid = 1'b0;
            ram_rvalid = (c == rv_c);
            ram_rdata  = {$urandom, $urandom};
        end
        ram_rvalid = 1'b0;
    endtask

    initial begin
        logic [63:0] a, r0, r1;
        int s0, s1, dc, rc, kp;
        rst           = 1'b1;
        ifu_mem_valid = 1'b0;
        ifu_mem_addr  = 64'd0;
        ram_rvalid    = 1'b0;
        ram_rdata     = 64'd0;
        exp_data      = 128'd0;
        exp_cnt       = 32'd0;
        exp_err       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 128'(ifu_mem_ready), 128'(1'b0));
        chk("rst_req", 128'(ram_req), 128'(1'b0));
        chk("rst_addr", 128'(ram_addr), 128'(64'd0));
        chk("rst_data", ifu_mem_data, 128'd0);
        chk("rst_err", 128'(err), 128'(1'b0));
        chk("rst_cnt", 128'(resp_cnt), 128'(32'd0));
        rst = 1'b0;
        @(negedge clk);

        // basic read, immediate data
        read_line(64'h8000_0004, 0, 0, 1'b0, 64'h1111, 64'h2222);
        chk("basic_data", ifu_mem_data, {64'h2222, 64'h1111});
        // two stalls per beat
        read_line(64'h8000_0040, 2, 2, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002);
        // flush in BEAT0, memory answers 3 cycles later; then simultaneous abort
        read_flush(64'h8000_0080, 1, 4);
        read_flush(64'h8000_00C8, 2, 2);
        // back-to-back lines
        read_line(64'h8000_0000, 0, 0, 1'b1, 64'hA0A0_A0A0_A0A0_A0A0, 64'hB1B1_B1B1_B1B1_B1B1);
        read_line(64'h8000_0010, 0, 0, 1'b0, 64'hC2C2_C2C2_C2C2_C2C2, 64'hD3D3_D3D3_D3D3_D3D3);
        chk("b2b_cnt", 128'(resp_cnt), 128'(32'd4));

        for (int i = 0; i < 16; i++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                dc = $urandom_range(1, 3);
                rc = $urandom_range(dc, TMO);
                read_flush(a, dc, rc);
            end else begin
                s0 = $urandom_range(0, 3);
                s1 = $urandom_range(0, 3);
                kp = $urandom_range(0, 1);
                r0 = {$urandom, $urandom};
                r1 = {$urandom, $urandom};
                read_line(a, s0, s1, kp != 0, r0, r1);
            end
        end

        // memory never answers: both beats time out, zero line returned
        read_line(64'h8000_0100, 99, 99, 1'b0, 64'h0, 64'h0);
        chk("tmo_data", ifu_mem_data, 128'd0);
        // err stays set across a later clean read
        read_line(64'h8000_0180, 1, 0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);

        // reset in the middle of BEAT1, then a stale rvalid
        ifu_mem_valid = 1'b1;
        ifu_mem_addr  = 64'h8000_0200;
        @(negedge clk);
        ram_rvalid = 1'b1;
        ram_rdata  = 64'h5555_5555_5555_5555;
        @(negedge clk);
        chk("mid_req", 128'(ram_req), 128'(1'b1));
        chk("mid_addr", 128'(ram_addr), 128'(64'h8000_0208));
        ram_rvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        exp_data = 128'd0;
        exp_cnt  = 32'd0;
        exp_err  = 1'b0;
        chk("mrst_ready", 128'(ifu_mem_ready), 128'(1'b0));
        chk("mrst_req", 128'(ram_req), 128'(1'b0));
        chk("mrst_addr", 128'(ram_addr), 128'(64'd0));
        chk("mrst_data", ifu_mem_data, 128'd0);
        chk("mrst_err", 128'(err), 128'(1'b0));
        chk("mrst_cnt", 128'(resp_cnt), 128'(32'd0));
        rst           = 1'b0;
        ifu_mem_valid = 1'b0;
        ram_rvalid    = 1'b1;
        ram_rdata     = 64'h7777_7777_7777_7777;
        @(negedge clk);
        chk("stale_req", 128'(ram_req), 128'(1'b0));
        chk("stale_ready", 128'(ifu_mem_ready), 128'(1'b0));
        chk("stale_data", ifu_mem_data, 128'd0);
        ram_rvalid = 1'b0;
        read_line(64'h8000_0300, 0, 1, 1'b0, 64'hABCD_0000_0000_0001, 64'hABCD_0000_0000_0002);
        idle_checks();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
